// File: rtl/dec16_pulse_driver.sv
// -----------------------------------------------------------------------------
// dec16_pulse_driver
//
// Purpose:
//   Sequenced 4-to-16 line decoder driver. A 4-bit line code is accepted
//   through a valid/ready handshake. The selected active-low line is then held
//   low for PULSE_W cycles. After that, all lines are held high for GAP_W
//   cycles. done pulses for one cycle during the last gap cycle. The 16 lines
//   are split into two 8-line banks (15..8 and 7..0).
//
//   All outputs are registered. They are computed from the next state, so
//   every output changes on the same edge as the state register.
//
// Parameters:
//   PULSE_W  cycles the selected line is held low     (1..255)
//   GAP_W    cycles all lines are held high afterwards (1..255)
//
// Ports:
//   clk         rising-edge clock
//   rst_N       asynchronous active-low reset
//   scan_en     auto-scan enable (only with DEC16_AUTOSCAN_EN defined)
//   EI_N        active-low enable; high aborts and forces all lines high
//   code[3:0]   line index to drive
//   valid       code is valid
//   ready       block accepts a code this cycle
//   out_15_8_N  active-low lines 15..8
//   out_7_0_N   active-low lines 7..0
//   busy_N      low while a pulse or gap is in progress
//   done        one-cycle pulse in the final gap cycle of a normal completion
//
// Optional feature macro: DEC16_AUTOSCAN_EN
//   When this macro is defined, the scan_en port is present. While
//   scan_en=1 and EI_N=0, the block issues codes 0..15 (wrapping) by itself
//   from IDLE, and ready is held 0.
// -----------------------------------------------------------------------------
module dec16_pulse_driver #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst_N,
`ifdef DEC16_AUTOSCAN_EN
  input  logic       scan_en,
`endif
  input  logic       EI_N,
  input  logic [3:0] code,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] out_15_8_N,
  output logic [7:0] out_7_0_N,
  output logic       busy_N,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_e;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_W - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] lines_q, lines_d;
  logic        busy_n_q, busy_n_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        scan_mode;

`ifdef DEC16_AUTOSCAN_EN
  logic [3:0]  scan_idx_q, scan_idx_d;
  assign scan_mode = scan_en & ~EI_N;
`else
  assign scan_mode = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default before any branch.
    // A path that leaves a signal unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
`ifdef DEC16_AUTOSCAN_EN
    scan_idx_d = scan_idx_q;
`endif

    if (EI_N) begin
      // Abort has priority over any handshake. No done pulse is produced.
      state_d = IDLE;
      cnt_d   = '0;
`ifdef DEC16_AUTOSCAN_EN
      scan_idx_d = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
`ifdef DEC16_AUTOSCAN_EN
          if (scan_mode) begin
            code_d     = scan_idx_q;
            scan_idx_d = scan_idx_q + 4'd1;
            state_d    = DRIVE;
            cnt_d      = '0;
          end else
`endif
          if (valid && ready_q) begin
            code_d  = code;
            state_d = DRIVE;
            cnt_d   = '0;
          end
        end
        DRIVE: begin
          if (cnt_q == PULSE_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are taken from the next state, so they line up with state_q.
    // Only DRIVE pulls a line low, so at most one line can ever be low.
    lines_d  = (state_d == DRIVE) ? ~(16'd1 << code_d) : 16'hFFFF;
    busy_n_d = (state_d == IDLE);
    done_d   = (state_d == GAP) && (cnt_d == GAP_LAST);
    ready_d  = (state_d == IDLE) && !EI_N && !scan_mode;
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together, whatever order the simulator evaluates them in.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      lines_q  <= 16'hFFFF;
      busy_n_q <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
`ifdef DEC16_AUTOSCAN_EN
      scan_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      lines_q  <= lines_d;
      busy_n_q <= busy_n_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
`ifdef DEC16_AUTOSCAN_EN
      scan_idx_q <= scan_idx_d;
`endif
    end
  end

  assign out_15_8_N = lines_q[15:8];
  assign out_7_0_N  = lines_q[7:0];
  assign busy_N     = busy_n_q;
  assign done       = done_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_dec16_pulse_driver.sv
// -----------------------------------------------------------------------------
// tb_dec16_pulse_driver
//
// Self-checking bench for dec16_pulse_driver with PULSE_W=4 and GAP_W=1.
// Inputs are driven 1 time unit after a rising edge. Outputs are checked at
// that same point, so they reflect the state after the edge.
// Packed observation: {ready, busy_N, done, out_15_8_N, out_7_0_N}.
// -----------------------------------------------------------------------------
module tb_dec16_pulse_driver;

  localparam int unsigned PULSE_W = 4;
  localparam int unsigned GAP_W   = 1;
  localparam int          NVEC    = 29;

  logic       clk;
  logic       rst_N;
  logic       EI_N;
  logic [3:0] code;
  logic       valid;
  logic       ready;
  logic [7:0] out_15_8_N;
  logic [7:0] out_7_0_N;
  logic       busy_N;
  logic       done;
`ifdef DEC16_AUTOSCAN_EN
  logic       scan_en;
`endif

  int checks   = 0;
  int failures = 0;

  dec16_pulse_driver #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .rst_N      (rst_N),
`ifdef DEC16_AUTOSCAN_EN
    .scan_en    (scan_en),
`endif
    .EI_N       (EI_N),
    .code       (code),
    .valid      (valid),
    .ready      (ready),
    .out_15_8_N (out_15_8_N),
    .out_7_0_N  (out_7_0_N),
    .busy_N     (busy_N),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ei_n;
    logic        valid;
    logic [3:0]  code;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [18:0] ex(input logic r, input logic b,
                                     input logic d, input logic [7:0] hi,
                                     input logic [7:0] lo);
    return {r, b, d, hi, lo};
  endfunction

  function automatic vec_t row(input logic ei_n, input logic v,
                               input logic [3:0] c, input logic [18:0] e);
    vec_t t;
    t.ei_n  = ei_n;
    t.valid = v;
    t.code  = c;
    t.exp   = e;
    return t;
  endfunction

  function automatic logic [18:0] obs();
    return {ready, busy_N, done, out_15_8_N, out_7_0_N};
  endfunction

  task automatic check(input string name, input logic [18:0] act,
                       input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h (ready,busy_N,done,hi,lo)",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [18:0] IDLE_RST = {1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF};
  localparam logic [18:0] IDLE_RDY = {1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF};
  localparam logic [18:0] GAP_LAST = {1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF};

  initial begin
    // Single code 0xA: line 10 = bit 2 of the high bank.
    vecs[0] = row(1'b0, 1'b1, 4'hA, ex(0, 0, 0, 8'hFB, 8'hFF));
    for (int i = 1; i <= 3; i++) vecs[i] = row(1'b0, 1'b0, 4'h0, ex(0, 0, 0, 8'hFB, 8'hFF));
    vecs[4] = row(1'b0, 1'b0, 4'h0, GAP_LAST);
    vecs[5] = row(1'b0, 1'b0, 4'h0, IDLE_RDY);
    // Back-to-back with valid held: code 0, then 15. Code changes during the
    // pulse must be ignored.
    vecs[6] = row(1'b0, 1'b1, 4'h0, ex(0, 0, 0, 8'hFF, 8'hFE));
    for (int i = 7; i <= 9; i++) vecs[i] = row(1'b0, 1'b1, 4'hF, ex(0, 0, 0, 8'hFF, 8'hFE));
    vecs[10] = row(1'b0, 1'b1, 4'hF, GAP_LAST);
    vecs[11] = row(1'b0, 1'b1, 4'hF, IDLE_RDY);
    vecs[12] = row(1'b0, 1'b1, 4'hF, ex(0, 0, 0, 8'h7F, 8'hFF));
    for (int i = 13; i <= 15; i++) vecs[i] = row(1'b0, 1'b0, 4'h0, ex(0, 0, 0, 8'h7F, 8'hFF));
    vecs[16] = row(1'b0, 1'b0, 4'h0, GAP_LAST);
    vecs[17] = row(1'b0, 1'b0, 4'h0, IDLE_RDY);
    // Code 3, with EI_N raised during the 2nd DRIVE cycle.
    vecs[18] = row(1'b0, 1'b1, 4'h3, ex(0, 0, 0, 8'hFF, 8'hF7));
    vecs[19] = row(1'b0, 1'b0, 4'h3, ex(0, 0, 0, 8'hFF, 8'hF7));
    vecs[20] = row(1'b1, 1'b1, 4'h3, IDLE_RST);
    vecs[21] = row(1'b1, 1'b1, 4'h3, IDLE_RST);
    // EI_N low again: ready only comes back after one edge, then code 5 is
    // accepted.
    vecs[22] = row(1'b0, 1'b1, 4'h5, IDLE_RDY);
    vecs[23] = row(1'b0, 1'b1, 4'h5, ex(0, 0, 0, 8'hFF, 8'hDF));
    for (int i = 24; i <= 26; i++) vecs[i] = row(1'b0, 1'b0, 4'h0, ex(0, 0, 0, 8'hFF, 8'hDF));
    vecs[27] = row(1'b0, 1'b0, 4'h0, GAP_LAST);
    vecs[28] = row(1'b0, 1'b0, 4'h0, IDLE_RDY);

    rst_N = 1'b1;
    EI_N  = 1'b0;
    valid = 1'b0;
    code  = 4'h0;
`ifdef DEC16_AUTOSCAN_EN
    scan_en = 1'b0;
`endif

    // Reset is applied before any clock edge, so the outputs must respond
    // asynchronously.
    #2 rst_N = 1'b0;
    #1 check("reset_async", obs(), IDLE_RST);
    tick();
    tick();
    check("reset_held", obs(), IDLE_RST);
    rst_N = 1'b1;
    tick();
    check("ready_after_release", obs(), IDLE_RDY);

    for (int i = 0; i < NVEC; i++) begin
      EI_N  = vecs[i].ei_n;
      valid = vecs[i].valid;
      code  = vecs[i].code;
      tick();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Reset pulsed in the middle of DRIVE, between clock edges. Code 9 is
    // bit 1 of the high bank.
    valid = 1'b1;
    code  = 4'h9;
    tick();
    check("rst_mid_drive_pre", obs(), ex(0, 0, 0, 8'hFD, 8'hFF));
    valid = 1'b0;
    tick();
    #2 rst_N = 1'b0;
    #1 check("rst_mid_drive_async", obs(), IDLE_RST);
    @(posedge clk);
    #1 rst_N = 1'b1;
    tick();
    check("rst_mid_drive_ready", obs(), IDLE_RDY);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rst_no_done%0d", i), obs(), IDLE_RDY);
    end

`ifdef DEC16_AUTOSCAN_EN
    // Auto-scan over 17 codes: 0..15, then 0 again. One line at a time.
    scan_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      logic [3:0]  idx;
      logic [15:0] lines;
      idx   = 4'(k % 16);
      lines = ~(16'd1 << idx);
      for (int c = 0; c < int'(PULSE_W); c++) begin
        tick();
        check($sformatf("scan%0d_drive%0d", k, c), obs(),
              ex(0, 0, 0, lines[15:8], lines[7:0]));
      end
      tick();
      check($sformatf("scan%0d_gap", k), obs(), GAP_LAST);
      tick();
      check($sformatf("scan%0d_idle", k), obs(), IDLE_RST);
    end
    scan_en = 1'b0;
    tick();
    check("scan_off_ready", obs(), IDLE_RDY);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
